// File: rtl/ln_pkg.sv
// Shared types and constants for the linearizer-normalizer sequencer.
package ln_pkg;

   localparam int P_DEF       = 32;
   localparam int RST_CYC_DEF = 4;
   localparam int TMO_CYC_DEF = 4095;
   localparam int CW_DEF      = 16;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_CLEAR = 3'd1,
      ST_LOAD  = 3'd2,
      ST_START = 3'd3,
      ST_WAIT  = 3'd4,
      ST_DONE  = 3'd5
   } ln_state_e;

   localparam logic [31:0] FP_ZERO = 32'h0000_0000;
   localparam logic [31:0] FP_HALF = 32'h3F00_0000;

endpackage

// File: rtl/ln_sequencer_if.sv
// Sample input, datapath control and result output of the sequencer.
// Both handshakes transfer on a rising edge where valid and ready are both high.
interface ln_sequencer_if #(
   parameter int P  = 32,
   parameter int CW = 16
);
   import ln_pkg::*;

   logic            IN_VALID;
   logic            IN_READY;
   logic [P-1:0]    I_IN;
   logic [P-1:0]    V_IN;
   logic            LN_RST;
   logic [P-1:0]    LN_I;
   logic [P-1:0]    LN_V;
   logic            LN_BEGIN_I;
   logic            LN_BEGIN_V;
   logic            LN_ACK_I;
   logic            LN_ACK_V;
   logic [P-1:0]    LN_RESULT_I;
   logic [P-1:0]    LN_RESULT_V;
   logic            OUT_VALID;
   logic            OUT_READY;
   logic [P-1:0]    RESULT_I_OUT;
   logic [P-1:0]    RESULT_V_OUT;
   logic            ERR_TMO;
   logic [CW-1:0]   SAMPLE_CNT;
   ln_state_e       DBG_STATE;

   modport slave (
      input  IN_VALID, I_IN, V_IN, LN_ACK_I, LN_ACK_V, LN_RESULT_I, LN_RESULT_V, OUT_READY,
      output IN_READY, LN_RST, LN_I, LN_V, LN_BEGIN_I, LN_BEGIN_V, OUT_VALID,
             RESULT_I_OUT, RESULT_V_OUT, ERR_TMO, SAMPLE_CNT, DBG_STATE
   );

   modport master (
      output IN_VALID, I_IN, V_IN, LN_ACK_I, LN_ACK_V, LN_RESULT_I, LN_RESULT_V, OUT_READY,
      input  IN_READY, LN_RST, LN_I, LN_V, LN_BEGIN_I, LN_BEGIN_V, OUT_VALID,
             RESULT_I_OUT, RESULT_V_OUT, ERR_TMO, SAMPLE_CNT, DBG_STATE
   );

endinterface

// File: rtl/ln_rst_sync.sv
// Active-low reset synchronizer: asserts asynchronously, releases after two clock edges.
module ln_rst_sync (
   input  logic i_clk,
   input  logic i_rst_n,
   output logic o_rst_n
);

   logic [1:0] r_sync;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) r_sync <= 2'b00;
      else          r_sync <= {r_sync[0], 1'b1};
   end

   assign o_rst_n = r_sync[1];

endmodule

// File: rtl/ln_sequencer.sv
// Sequences clear/load/begin of the I,V linearizer datapath per sample and
// returns the ACK-captured result pair, with a timeout on missing ACKs.
module ln_sequencer
   import ln_pkg::*;
#(
   parameter int P       = P_DEF,
   parameter int RST_CYC = RST_CYC_DEF,
   parameter int TMO_CYC = TMO_CYC_DEF,
   parameter int CW      = CW_DEF
) (
   input  logic          CLK,
   input  logic          RST_N,
   ln_sequencer_if.slave bus
);

   logic          w_rst_n;
   ln_state_e     r_state, w_next;
   logic [7:0]    r_cnt;
   logic [15:0]   r_tmo;
   logic          r_seen_i, r_seen_v;
   logic          w_got_i, w_got_v;
   logic          r_in_ready, r_ln_rst, r_begin, r_out_valid, r_err_tmo;
   logic          w_in_ready_nxt, w_ln_rst_nxt, w_begin_nxt, w_out_valid_nxt;
   logic [P-1:0]  r_ln_i, r_ln_v, r_res_i, r_res_v;
   logic [CW-1:0] r_sample_cnt;

   ln_rst_sync u_rst_sync (
      .i_clk   (CLK),
      .i_rst_n (RST_N),
      .o_rst_n (w_rst_n)
   );

   // An ACK counts as seen on the edge it first appears as well as afterwards.
   assign w_got_i = r_seen_i | bus.LN_ACK_I;
   assign w_got_v = r_seen_v | bus.LN_ACK_V;

   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE:  if (bus.IN_VALID && r_in_ready) w_next = ST_CLEAR;
         ST_CLEAR: if (r_cnt == 8'd0) w_next = ST_LOAD;
         ST_LOAD:  w_next = ST_START;
         ST_START: w_next = ST_WAIT;
         ST_WAIT:  if ((w_got_i && w_got_v) || (r_tmo == 16'd0)) w_next = ST_DONE;
         ST_DONE:  if (bus.OUT_READY) w_next = ST_IDLE;
         default:  w_next = ST_IDLE;
      endcase
      w_in_ready_nxt  = (w_next == ST_IDLE);
      w_ln_rst_nxt    = (w_next == ST_IDLE) || (w_next == ST_CLEAR);
      w_begin_nxt     = (w_next == ST_START);
      w_out_valid_nxt = (w_next == ST_DONE);
   end

   // Control outputs are registered copies of the next-state decode so they line up with r_state.
   always_ff @(posedge CLK or negedge w_rst_n) begin
      if (!w_rst_n) begin
         r_state     <= ST_IDLE;
         r_in_ready  <= 1'b0;
         r_ln_rst    <= 1'b1;
         r_begin     <= 1'b0;
         r_out_valid <= 1'b0;
      end else begin
         r_state     <= w_next;
         r_in_ready  <= w_in_ready_nxt;
         r_ln_rst    <= w_ln_rst_nxt;
         r_begin     <= w_begin_nxt;
         r_out_valid <= w_out_valid_nxt;
      end
   end

   always_ff @(posedge CLK or negedge w_rst_n) begin
      if (!w_rst_n) begin
         r_cnt        <= 8'd0;
         r_tmo        <= 16'd0;
         r_seen_i     <= 1'b0;
         r_seen_v     <= 1'b0;
         r_ln_i       <= '0;
         r_ln_v       <= '0;
         r_res_i      <= '0;
         r_res_v      <= '0;
         r_err_tmo    <= 1'b0;
         r_sample_cnt <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (bus.IN_VALID && r_in_ready) begin
                  r_ln_i <= bus.I_IN;
                  r_ln_v <= bus.V_IN;
                  r_cnt  <= 8'(RST_CYC - 1);
               end
            end
            ST_CLEAR: if (r_cnt != 8'd0) r_cnt <= r_cnt - 8'd1;
            ST_START: begin
               r_seen_i <= 1'b0;
               r_seen_v <= 1'b0;
               r_tmo    <= 16'(TMO_CYC - 1);
            end
            ST_WAIT: begin
               if (bus.LN_ACK_I && !r_seen_i) begin
                  r_res_i  <= bus.LN_RESULT_I;
                  r_seen_i <= 1'b1;
               end
               if (bus.LN_ACK_V && !r_seen_v) begin
                  r_res_v  <= bus.LN_RESULT_V;
                  r_seen_v <= 1'b1;
               end
               if (w_got_i && w_got_v) begin
                  r_err_tmo <= 1'b0;
               end else if (r_tmo == 16'd0) begin
                  r_err_tmo <= 1'b1;
                  if (!w_got_i) r_res_i <= '0;
                  if (!w_got_v) r_res_v <= '0;
               end else begin
                  r_tmo <= r_tmo - 16'd1;
               end
            end
            ST_DONE: if (bus.OUT_READY) r_sample_cnt <= r_sample_cnt + CW'(1);
            default: ;
         endcase
      end
   end

   assign bus.IN_READY     = r_in_ready;
   assign bus.LN_RST       = r_ln_rst;
   assign bus.LN_I         = r_ln_i;
   assign bus.LN_V         = r_ln_v;
   assign bus.LN_BEGIN_I   = r_begin;
   assign bus.LN_BEGIN_V   = r_begin;
   assign bus.OUT_VALID    = r_out_valid;
   assign bus.RESULT_I_OUT = r_res_i;
   assign bus.RESULT_V_OUT = r_res_v;
   assign bus.ERR_TMO      = r_err_tmo;
   assign bus.SAMPLE_CNT   = r_sample_cnt;
   assign bus.DBG_STATE    = r_state;

endmodule
